k6502_oam_dma: RTL and testbench
================================

# k6502_oam_dma

Sprite-DMA bus master and CPU-stall arbiter that sits beside the k6502 core on the shared CPU address/data bus. A CPU write to the trigger register latches a source page. The block then stalls the core via `rdy` and waits for the core to reach a read cycle. It takes the bus and copies 256 bytes from `{page,8'h00..8'hFF}` to the OAM data port with alternating read/write cycles, then returns the bus. The top level muxes the core's and this block's address/data/write outputs using `bus_grant`.

## Interface
Parameters:
- `TRIG_ADDR`, default `16'h4014`: CPU write address that starts a transfer.
- `DEST_ADDR`, default `16'h2004`: fixed destination address for every DMA write.

Ports (one clock; reset is synchronous and active-high):
- `clk` input, 1: system clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `cpu_a` input, 16: core address output.
- `cpu_dout` input, 8: core write data.
- `cpu_we` input, 1: core write strobe (1 = write cycle).
- `bus_din` input, 8: read data returned from the bus.
- `rdy` output, 1: to core; 0 stalls the core on its next read cycle.
- `bus_grant` output, 1: 1 = block owns the bus; top-level mux selects `dma_*`.
- `dma_a` output, 16: DMA address.
- `dma_dout` output, 8: DMA write data.
- `dma_we` output, 1: DMA write strobe.
- `busy` output, 1: transfer pending or in progress.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Phase flop `phase`: reset 0, toggles every cycle unconditionally. It is independent of state.
- IDLE: a clock edge with `cpu_we`=1 and `cpu_a`==TRIG_ADDR latches `page<=cpu_dout` and `cnt<=0`, then goes to HALT. All other writes are ignored, including writes to TRIG_ADDR±1.
- HALT: `rdy`=0. The core can only stall on reads, so the block waits for an edge where `cpu_we`=0. At that edge: if `phase`==0, go to READ; otherwise go to ALIGN.
- ALIGN: one dummy cycle. `bus_grant`=1, `dma_we`=0, `dma_a={page,8'h00}`. Next state is READ.
- READ: `dma_a={page,cnt}`, `dma_we`=0. `bus_din` is captured into `buf` at the end of the cycle. Next state is WRITE.
- WRITE: `dma_a`=DEST_ADDR, `dma_dout=buf`, `dma_we`=1. Then:
  - if `cnt`==8'hFF, go to IDLE;
  - otherwise `cnt<=cnt+1` and go to READ.
- `cnt` is 8 bits. The source address never carries into the page byte: page $FF stays within $FF00–$FFFF.
- A TRIG_ADDR write seen in any non-IDLE state is ignored. It cannot normally occur, because the core is stalled.
- `rst` in any state forces IDLE on the next edge. The partial transfer is abandoned and not resumed.
- Outputs when not granted: `dma_a`=0, `dma_dout`=0, `dma_we`=0.
- Reset values: state IDLE, `rdy`=1, `bus_grant`=0, `busy`=0, `dma_we`=0, `dma_a`=0, `dma_dout`=0, `page`=0, `cnt`=0, `buf`=0, `phase`=0.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `cpu_*` to outputs.
- Trigger write at edge T: at T+1, `rdy`=0 and `busy`=1.
- `bus_grant`=1 exactly in ALIGN/READ/WRITE.
- Grant length is 512 cycles, or 513 when ALIGN is taken.
- Total stall from trigger edge to `rdy`=1 is 1 + (HALT wait cycles) + 512/513.
- Last WRITE cycle: at the following edge, `rdy`=1, `bus_grant`=0, `busy`=0 together.
- `rdy` stays 0 from HALT through the final WRITE. The top level must never see `bus_grant`=1 while `rdy`=1.

## Structure
- Add to `k6502_defs.v`:
  - state encodings `DMA_IDLE`, `DMA_HALT`, `DMA_ALIGN`, `DMA_READ`, `DMA_WRITE`;
  - `DMA_TRIG_ADDR` and `DMA_DEST_ADDR` defaults.
- Single module, no sub-modules. The bus mux stays in the top level.

## Test plan
- Basic transfer, even alignment:
  - Stimulus: write $02 to $4014, core reads on the next cycle, `phase`=0 at HALT exit; memory $0200+i = i^8'h5A.
  - Required: 512 grant cycles; 256 writes to $2004 with data i^8'h5A in order; `rdy` returns to 1.
- Odd alignment: same transfer with `phase`=1 at HALT exit → exactly one ALIGN cycle (no write), 513 grant cycles, same data sequence.
- Halt waiting on core writes: hold `cpu_we`=1 for 3 cycles after the trigger → `bus_grant` stays 0 and `rdy` stays 0 for those cycles; grant begins only after the first `cpu_we`=0 edge.
- Page wrap: page $FF → source addresses run $FF00..$FFFF and never reach $0000; final WRITE is followed by IDLE.
- Reset mid-transfer:
  - Stimulus: assert `rst` for one cycle during the READ of `cnt`=100.
  - Required: next cycle `rdy`=1, `bus_grant`=0, `busy`=0, `dma_we`=0; no further $2004 writes; a new trigger restarts at `cnt`=0.
- Non-trigger writes: writes to $4013, $4015, and a read of $4014 → `busy` stays 0 and `rdy` stays 1.

Source files
------------

// File: rtl/k6502_oam_dma_pkg.sv
// Shared definitions for the k6502 sprite-DMA block: state encoding and default addresses.
package k6502_oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] DMA_DEST_ADDR = 16'h2004;

endpackage

// File: rtl/k6502_oam_dma_if.sv
// CPU-side bus taps plus the DMA master outputs; master = DMA block, slave = top-level bus mux.
interface k6502_oam_dma_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  bus_din;
  logic        rdy;
  logic        bus_grant;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        busy;

  modport master (
    input  cpu_a, cpu_dout, cpu_we, bus_din,
    output rdy, bus_grant, dma_a, dma_dout, dma_we, busy
  );

  modport slave (
    output cpu_a, cpu_dout, cpu_we, bus_din,
    input  rdy, bus_grant, dma_a, dma_dout, dma_we, busy
  );
endinterface

// File: rtl/k6502_oam_dma.sv
// Sprite-DMA bus master: stalls the core, copies a 256-byte page to the OAM data port, releases the bus.
module k6502_oam_dma
  import k6502_oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = DMA_TRIG_ADDR,
  parameter logic [15:0] DEST_ADDR = DMA_DEST_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  k6502_oam_dma_if.master        bus
);

  dma_state_e state;
  logic       phase;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] data_buf;

  // Outputs are loaded alongside the state they belong to, so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DMA_IDLE;
      phase         <= 1'b0;
      page          <= 8'h00;
      cnt           <= 8'h00;
      data_buf      <= 8'h00;
      bus.rdy       <= 1'b1;
      bus.bus_grant <= 1'b0;
      bus.busy      <= 1'b0;
      bus.dma_we    <= 1'b0;
      bus.dma_a     <= 16'h0000;
      bus.dma_dout  <= 8'h00;
    end else begin
      phase <= ~phase;
      case (state)
        DMA_IDLE: begin
          if (bus.cpu_we && bus.cpu_a == TRIG_ADDR) begin
            page     <= bus.cpu_dout;
            cnt      <= 8'h00;
            state    <= DMA_HALT;
            bus.rdy  <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        DMA_HALT: begin
          // The core only honours rdy on reads, so the bus is free once it reads.
          if (!bus.cpu_we) begin
            state         <= phase ? DMA_ALIGN : DMA_READ;
            bus.bus_grant <= 1'b1;
            bus.dma_a     <= {page, 8'h00};
          end
        end
        DMA_ALIGN: begin
          state     <= DMA_READ;
          bus.dma_a <= {page, cnt};
        end
        DMA_READ: begin
          data_buf     <= bus.bus_din;
          state        <= DMA_WRITE;
          bus.dma_a    <= DEST_ADDR;
          bus.dma_dout <= bus.bus_din;
          bus.dma_we   <= 1'b1;
        end
        DMA_WRITE: begin
          bus.dma_we   <= 1'b0;
          bus.dma_dout <= 8'h00;
          if (cnt == 8'hFF) begin
            state         <= DMA_IDLE;
            bus.rdy       <= 1'b1;
            bus.bus_grant <= 1'b0;
            bus.busy      <= 1'b0;
            bus.dma_a     <= 16'h0000;
          end else begin
            // cnt wraps inside the page; the page byte is never incremented.
            cnt       <= cnt + 8'd1;
            state     <= DMA_READ;
            bus.dma_a <= {page, cnt + 8'd1};
          end
        end
        default: begin
          state         <= DMA_IDLE;
          bus.rdy       <= 1'b1;
          bus.bus_grant <= 1'b0;
          bus.busy      <= 1'b0;
          bus.dma_we    <= 1'b0;
          bus.dma_a     <= 16'h0000;
          bus.dma_dout  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k6502_oam_dma.sv
// Directed-plus-random bench for k6502_oam_dma against a transfer-level reference model.
module tb_k6502_oam_dma;
  import k6502_oam_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k6502_oam_dma_if bus();
  k6502_oam_dma dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [0:65535];
  assign bus.bus_din = mem[bus.bus_grant ? bus.dma_a : bus.cpu_a];

  int tests = 0;
  int fails = 0;

  // Free-running parity since the last reset edge: the value the block samples at the next edge.
  logic ph_m;
  always @(posedge clk) ph_m <= rst ? 1'b0 : ~ph_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_we   = we;
    bus.cpu_a    = a;
    bus.cpu_dout = d;
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_rdy"},  bus.rdy,  1'b1);
    chk({tag, "_gnt"},  bus.bus_grant, 1'b0);
  endtask

  // One full transfer. want_align: 0/1 forces HALT-exit parity, 2 leaves it free.
  // abort_cnt >= 0 pulses rst during the read of that byte.
  task automatic xfer(input logic [7:0] pg, input int holds, input int want_align, input int abort_cnt);
    int h, gcyc, stall, bad_rdy, bad_rd, bad_wr, bad_wa, bad_seq, idle_bad;
    logic align_exp;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [15:0] exp_rd[$];
    h = 0; gcyc = 0; stall = 0; bad_rdy = 0; bad_rd = 0; bad_wr = 0; bad_wa = 0; bad_seq = 0;

    step(1'b1, DMA_TRIG_ADDR, pg);
    chk("trig_rdy", bus.rdy, 1'b0);
    chk("trig_busy", bus.busy, 1'b1);
    stall++;

    // Core keeps writing (some to the trigger address, which must be ignored).
    while (h < holds || (want_align != 2 && ph_m != want_align[0])) begin
      step(1'b1, (h % 2 == 1) ? DMA_TRIG_ADDR : 16'($urandom), 8'($urandom));
      h++;
      chk("halt_gnt", bus.bus_grant, 1'b0);
      chk("halt_rdy", bus.rdy, 1'b0);
      if (bus.rdy === 1'b0) stall++;
    end

    align_exp    = ph_m;
    bus.cpu_we   = 1'b0;
    bus.cpu_a    = 16'($urandom);

    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (i == 0) chk("grant_start", bus.bus_grant, 1'b1);
      if (bus.bus_grant !== 1'b1) break;
      gcyc++;
      if (bus.rdy !== 1'b0) bad_rdy++; else stall++;
      if ((gcyc - 1) >= int'(align_exp)) begin
        if (bus.dma_we !== (((gcyc - 1 - int'(align_exp)) % 2) == 1)) bad_seq++;
      end else if (bus.dma_we !== 1'b0) bad_seq++;
      if (bus.dma_we === 1'b1) begin
        if (bus.dma_a !== DMA_DEST_ADDR) bad_wa++;
        wr_q.push_back(bus.dma_dout);
      end else begin
        rd_q.push_back(bus.dma_a);
      end
      if (abort_cnt >= 0 && bus.dma_we === 1'b0 && gcyc > int'(align_exp) &&
          bus.dma_a === {pg, 8'(abort_cnt)}) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rdy", bus.rdy, 1'b1);
        chk("abort_gnt", bus.bus_grant, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_we", bus.dma_we, 1'b0);
        chk("abort_writes", wr_q.size(), abort_cnt);
        idle_bad = 0;
        for (int k = 0; k < 8; k++) begin
          bus.cpu_a = 16'($urandom);
          @(negedge clk);
          if (bus.bus_grant !== 1'b0 || bus.dma_we !== 1'b0 || bus.busy !== 1'b0) idle_bad++;
        end
        chk("abort_quiet", idle_bad, 0);
        return;
      end
    end

    chk("end_rdy", bus.rdy, 1'b1);
    chk("end_gnt", bus.bus_grant, 1'b0);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_we", bus.dma_we, 1'b0);
    chk("grant_cycles", gcyc, 512 + int'(align_exp));
    chk("stall_cycles", stall, 1 + h + 512 + int'(align_exp));
    chk("rdy_in_grant", bad_rdy, 0);
    chk("rw_sequence", bad_seq, 0);

    if (align_exp) exp_rd.push_back({pg, 8'h00});
    for (int i = 0; i < 256; i++) exp_rd.push_back({pg, 8'(i)});
    chk("rd_count", rd_q.size(), exp_rd.size());
    chk("wr_count", wr_q.size(), 256);
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      if (rd_q[i] !== exp_rd[i]) bad_rd++;
    for (int i = 0; i < wr_q.size() && i < 256; i++)
      if (wr_q[i] !== mem[{pg, 8'(i)}]) bad_wr++;
    chk("rd_addr", bad_rd, 0);
    chk("wr_data", bad_wr, 0);
    chk("wr_addr", bad_wa, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    bus.cpu_we = 1'b0; bus.cpu_a = 16'h0000; bus.cpu_dout = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.rdy, 1'b1);
    chk("rst_gnt", bus.bus_grant, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_we", bus.dma_we, 1'b0);
    chk("rst_a", bus.dma_a, 16'h0000);
    chk("rst_dout", bus.dma_dout, 8'h00);
    rst = 1'b0;
    step(1'b0, 16'h0000, 8'h00);

    step(1'b1, 16'h4013, 8'h02); idle_chk("wr4013");
    step(1'b1, 16'h4015, 8'h02); idle_chk("wr4015");
    step(1'b0, 16'h4014, 8'h02); idle_chk("rd4014");
    step(1'b0, 16'h0000, 8'h00); idle_chk("idle");

    xfer(8'h02, 0, 0, -1);
    idle_chk("post_even");
    xfer(8'h02, 0, 1, -1);
    idle_chk("post_odd");
    xfer(8'h02, 3, 2, -1);
    xfer(8'hFF, int'($urandom_range(0, 4)), 2, -1);
    step(1'b0, 16'h0000, 8'h00); idle_chk("post_wrap");

    xfer(8'h37, 1, 2, 100);
    xfer(8'h37, 0, 2, -1);

    for (int n = 0; n < 2; n++) begin
      step(1'b0, 16'($urandom), 8'h00);
      xfer(8'($urandom), int'($urandom_range(0, 3)), 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
